// File: rtl/pam4_symbol_source.sv
// ---------------------------------------------------------------------------
// pam4_symbol_source
//
// Transmit-side 4-ASK symbol generator. Each frame is PREAMBLE_LEN alternating
// outer-level symbols followed by FRAME_LEN PN data symbols taken from a
// 15-bit LFSR (x^15 + x^14 + 1), Gray mapped onto {-3a, -a, +a, +3a}.
// Between frames the source idles on level 0.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   sam_clk_ena  in   sample-rate strobe (1 clk in 4)
//   sym_clk_ena  in   symbol-rate strobe (1 clk in 16), coincides with sam_clk_ena
//   start        in   frame request, level or pulse, honoured only while idle
//   sam_out      out  zero-stuffed sample stream [S,0,0,0] per symbol
//   sym_out      out  current symbol level, held for a symbol period
//   sym_bits     out  Gray bit pair of the current symbol
//   busy         out  high from preamble symbol 0 through the last data symbol
//   frame_done   out  one-clk pulse on the edge issuing the last data symbol
//   sym_count    out  index of the current symbol within its phase
// ---------------------------------------------------------------------------
module pam4_symbol_source #(
  parameter int          WIDTH        = 18,
  parameter int          LEVEL_A      = 32768,
  parameter logic [14:0] LFSR_SEED    = 15'h0001,
  parameter int          PREAMBLE_LEN = 16,
  parameter int          FRAME_LEN    = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sam_clk_ena,
  input  logic                    sym_clk_ena,
  input  logic                    start,
  output logic signed [WIDTH-1:0] sam_out,
  output logic signed [WIDTH-1:0] sym_out,
  output logic [1:0]              sym_bits,
  output logic                    busy,
  output logic                    frame_done,
  output logic [8:0]              sym_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA
  } state_e;

  localparam logic signed [WIDTH-1:0] LVL_P3 = WIDTH'(3 * LEVEL_A);
  localparam logic signed [WIDTH-1:0] LVL_P1 = WIDTH'(LEVEL_A);
  localparam logic signed [WIDTH-1:0] LVL_N1 = WIDTH'(-LEVEL_A);
  localparam logic signed [WIDTH-1:0] LVL_N3 = WIDTH'(-3 * LEVEL_A);

  localparam logic [8:0] PRE_LAST  = 9'(PREAMBLE_LEN - 1);
  localparam logic [8:0] DATA_LAST = 9'(FRAME_LEN - 1);

  // Gray map: adjacent levels differ in exactly one bit.
  function automatic logic signed [WIDTH-1:0] gray_level(input logic [1:0] bits);
    case (bits)
      2'b00:   gray_level = LVL_N3;
      2'b01:   gray_level = LVL_N1;
      2'b11:   gray_level = LVL_P1;
      default: gray_level = LVL_P3;
    endcase
  endfunction

  function automatic logic [14:0] lfsr_step(input logic [14:0] s);
    lfsr_step = {s[13:0], s[14] ^ s[13]};
  endfunction

  state_e                  state_q,     state_d;
  logic [8:0]              cnt_q,       cnt_d;
  logic [14:0]             lfsr_q,      lfsr_d;
  logic                    pending_q,   pending_d;
  logic signed [WIDTH-1:0] sam_out_q,   sam_out_d;
  logic signed [WIDTH-1:0] sym_out_q,   sym_out_d;
  logic [1:0]              sym_bits_q,  sym_bits_d;
  logic [8:0]              sym_count_q, sym_count_d;
  logic                    busy_q,      busy_d;
  logic                    done_q,      done_d;

  logic [1:0]              issue_bits;
  logic signed [WIDTH-1:0] issue_level;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    lfsr_d      = lfsr_q;
    sam_out_d   = sam_out_q;
    sym_out_d   = sym_out_q;
    sym_bits_d  = sym_bits_q;
    sym_count_d = sym_count_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    issue_bits  = 2'b00;
    issue_level = '0;

    // A request is only latched while idle; requests during a frame are dropped.
    pending_d = pending_q | (start & (state_q == ST_IDLE));

    // sym_clk_ena alone is still treated as a symbol edge.
    if (sym_clk_ena) begin
      case (state_q)
        ST_IDLE: begin
          busy_d      = 1'b0;
          sym_count_d = '0;
          if (pending_q) begin
            pending_d = 1'b0;
            lfsr_d    = LFSR_SEED;
            cnt_d     = '0;
            state_d   = ST_PREAMBLE;
          end
        end

        ST_PREAMBLE: begin
          issue_bits  = cnt_q[0] ? 2'b00 : 2'b10;
          issue_level = gray_level(issue_bits);
          sym_count_d = cnt_q;
          busy_d      = 1'b1;
          if (cnt_q == PRE_LAST) begin
            cnt_d   = '0;
            state_d = ST_DATA;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end

        ST_DATA: begin
          issue_bits  = {lfsr_q[14], lfsr_q[13]};
          issue_level = gray_level(issue_bits);
          lfsr_d      = lfsr_step(lfsr_step(lfsr_q));
          sym_count_d = cnt_q;
          busy_d      = 1'b1;
          if (cnt_q == DATA_LAST) begin
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end

        default: state_d = ST_IDLE;
      endcase

      sym_bits_d = issue_bits;
      sym_out_d  = issue_level;
      sam_out_d  = issue_level;
    end else if (sam_clk_ena) begin
      // Zero-stuffing: the three non-symbol sample slots carry 0.
      sam_out_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      pending_q   <= 1'b0;
      sam_out_q   <= '0;
      sym_out_q   <= '0;
      sym_bits_q  <= '0;
      sym_count_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      pending_q   <= pending_d;
      sam_out_q   <= sam_out_d;
      sym_out_q   <= sym_out_d;
      sym_bits_q  <= sym_bits_d;
      sym_count_q <= sym_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign sam_out    = sam_out_q;
  assign sym_out    = sym_out_q;
  assign sym_bits   = sym_bits_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign sym_count  = sym_count_q;

endmodule

// File: tb/tb_pam4_symbol_source.sv
// ---------------------------------------------------------------------------
// tb_pam4_symbol_source
//
// Self-checking bench for pam4_symbol_source. The expected frame (preamble
// plus PN data) is computed up front with plain integer arithmetic; the bench
// then walks symbol by symbol, checking the symbol-rate outputs at each
// symbol edge and the zero-stuffed sample stream on every clk.
// ---------------------------------------------------------------------------
module tb_pam4_symbol_source;

  localparam int A     = 32768;
  localparam int PRE   = 16;
  localparam int DATA  = 256;
  localparam int TOTAL = PRE + DATA;

  logic               clk = 1'b0;
  logic               reset;
  logic               sam_clk_ena;
  logic               sym_clk_ena;
  logic               start;
  logic signed [17:0] sam_out;
  logic signed [17:0] sym_out;
  logic [1:0]         sym_bits;
  logic               busy;
  logic               frame_done;
  logic [8:0]         sym_count;

  int vectors     = 0;
  int miscompares = 0;

  int ref_lvl  [TOTAL];
  int ref_bits [TOTAL];

  pam4_symbol_source dut (
    .clk         (clk),
    .reset       (reset),
    .sam_clk_ena (sam_clk_ena),
    .sym_clk_ena (sym_clk_ena),
    .start       (start),
    .sam_out     (sam_out),
    .sym_out     (sym_out),
    .sym_bits    (sym_bits),
    .busy        (busy),
    .frame_done  (frame_done),
    .sym_count   (sym_count)
  );

  always #5 clk = ~clk;

  // Free-running strobes, changed on the falling edge.
  initial begin
    int phase = 15;
    sam_clk_ena = 1'b0;
    sym_clk_ena = 1'b0;
    forever begin
      @(negedge clk);
      phase       = (phase + 1) % 16;
      sam_clk_ena = (phase % 4 == 0);
      sym_clk_ena = (phase == 0);
    end
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference frame from the symbol rules: alternating +3a/-3a preamble,
  // then LFSR bit pairs mapped 00->-3a, 01->-a, 10->+3a, 11->+a.
  task automatic build_frame();
    int s = 1;
    int map [4] = '{-3 * A, -A, 3 * A, A};
    for (int i = 0; i < PRE; i++) begin
      ref_lvl[i]  = (i % 2 == 0) ? 3 * A : -3 * A;
      ref_bits[i] = (i % 2 == 0) ? 2 : 0;
    end
    for (int j = 0; j < DATA; j++) begin
      int b = ((s >> 14) & 1) * 2 + ((s >> 13) & 1);
      ref_bits[PRE + j] = b;
      ref_lvl[PRE + j]  = map[b];
      for (int st = 0; st < 2; st++)
        s = ((s << 1) | (((s >> 14) ^ (s >> 13)) & 1)) & 32'h7fff;
    end
  endtask

  task automatic wait_sym_edge();
    int n = 0;
    bit seen;
    do begin
      @(posedge clk);
      n++;
      seen = sym_clk_ena;
    end while (!seen && n < 40);
    #1;
    check("sym_edge_seen", 32'(seen), 1);
  endtask

  task automatic check_all_zero(input string where);
    check({where, "_sam_out"},    sam_out,    0);
    check({where, "_sym_out"},    sym_out,    0);
    check({where, "_sym_bits"},   sym_bits,   0);
    check({where, "_sym_count"},  sym_count,  0);
    check({where, "_busy"},       busy,       0);
    check({where, "_frame_done"}, frame_done, 0);
  endtask

  // One symbol period: edge checks, then 15 clks of sample-stream checks.
  // raise_k/drop_k drive start mid-symbol; rst asserts reset after the edge.
  task automatic run_symbol(input int lvl, input int bits, input int cnt,
                            input int bsy, input int done, input int raise_k,
                            input int drop_k, input bit rst);
    wait_sym_edge();
    check("sym_out",    sym_out,    lvl);
    check("sym_bits",   sym_bits,   bits);
    check("sym_count",  sym_count,  cnt);
    check("busy",       busy,       bsy);
    check("frame_done", frame_done, done);
    check("sam_out_s",  sam_out,    lvl);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
        check("sam_out", sam_out, (k < 4) ? lvl : 0);
        check("frame_done_pulse", frame_done, 0);
      end
      if (rst && k == 0) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("mid_reset");
        reset = 1'b0;
        return;
      end
      if (k == raise_k) start = 1'b1;
      if (k == drop_k)  start = 1'b0;
    end
  endtask

  task automatic idle_symbols(input int n);
    for (int i = 0; i < n; i++) run_symbol(0, 0, 0, 0, 0, -1, -1, 1'b0);
  endtask

  // Single-clk start pulse at a random point inside an idle symbol; the next
  // symbol edge consumes it (still a zero symbol), the preamble follows.
  task automatic request_frame();
    int k = $urandom_range(0, 13);
    idle_symbols($urandom_range(0, 3));
    run_symbol(0, 0, 0, 0, 0, k, k + 1, 1'b0);
    idle_symbols(1);
  endtask

  task automatic run_frame(input bit hold, input int rst_at);
    for (int i = 0; i < PRE; i++)
      run_symbol(ref_lvl[i], ref_bits[i], i, 1, 0, -1, -1, 1'b0);
    for (int j = 0; j < DATA; j++) begin
      run_symbol(ref_lvl[PRE + j], ref_bits[PRE + j], j, 1, (j == DATA - 1) ? 1 : 0,
                 (hold && j == 0) ? 0 : -1, (hold && j == DATA - 1) ? 1 : -1,
                 j == rst_at);
      if (j == rst_at) return;
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    build_frame();

    repeat (20) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    idle_symbols(10);

    // Frame 1: start held high through the data phase and one clk past
    // frame_done, which re-arms a back-to-back frame.
    request_frame();
    run_frame(1'b1, -1);
    idle_symbols(1);

    // Frame 2: identical sequence, cut by reset at data symbol 100.
    run_frame(1'b0, 100);

    // Frame 3: a fresh start replays the sequence from data symbol 0.
    idle_symbols(2);
    request_frame();
    run_frame(1'b0, -1);
    idle_symbols(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pam4_symbol_source.md
Name: pam4_symbol_source

Overview:
- Transmit-side symbol generator for the DSP modem. Sits directly downstream of the clock-enable generator and consumes its sam_clk_ena (1-in-4 clk) and sym_clk_ena (1-in-16 clk) strobes.
- Emits framed 4-ASK symbols: a fixed alternating preamble, then PN data from an internal LFSR.
- Presents each symbol at sample rate, zero-stuffed 4x, to the pulse-shaping filter, and holds it at symbol rate for monitoring and slicer reference.

Parameters:
- WIDTH, 18: output sample width, signed two's complement, 1s17 format.
- LEVEL_A, 32768: inner level magnitude a (0.25 full scale). Outer level is 3*LEVEL_A = 98304.
- LFSR_SEED, 15'h0001: LFSR load value at frame start. Must be nonzero.
- PREAMBLE_LEN, 16: number of preamble symbols per frame.
- FRAME_LEN, 256: number of data symbols per frame.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- sam_clk_ena, input, 1: sample-rate enable, one clk wide, every 4 clk.
- sym_clk_ena, input, 1: symbol-rate enable, one clk wide, every 16 clk. Always coincides with a sam_clk_ena.
- start, input, 1: request one frame. Level or pulse accepted.
- sam_out, output, WIDTH: zero-stuffed sample stream to the pulse-shaping filter.
- sym_out, output, WIDTH: current symbol level, held for one symbol period.
- sym_bits, output, 2: Gray bit pair of the current symbol.
- busy, output, 1: high while in PREAMBLE or DATA.
- frame_done, output, 1: one-clk pulse when the last data symbol is issued.
- sym_count, output, 9: index of the current symbol within the current phase.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, start_pending = 0, LFSR = LFSR_SEED, counters = 0.
- Registered outputs. All updates occur on the clk edge where the corresponding enable is high, so latency is 1 clk from the enable cycle. Outputs hold between enables.
- sam_out:
  - On the sam_clk_ena edge with sym_clk_ena also high: load the new symbol level.
  - On the sam_clk_ena edge with sym_clk_ena low: load 0.
  - Result: pattern per symbol is [S,0,0,0], each value held 4 clk.
- sym_out, sym_bits, sym_count: update only on sym_clk_ena edges.
- Mapping (Gray): 00 -> -3a, 01 -> -a, 11 -> +a, 10 -> +3a. Arithmetic is saturation-free given the default levels.
- LFSR: 15-bit, polynomial x^15+x^14+1.
  - One step: fb = lfsr[14]^lfsr[13]; lfsr <= {lfsr[13:0], fb}.
  - Each DATA symbol takes bits {lfsr[14], lfsr[13]} from the current state, then advances the LFSR two steps on the same edge.
- start handling:
  - start high in any cycle while in IDLE sets start_pending.
  - start while busy is ignored; no queuing.
- FSM state IDLE:
  - On sym_clk_ena: emit level 0, sym_bits 00.
  - If start_pending: clear it, load LFSR = LFSR_SEED, sym_count = 0, go to PREAMBLE.
  - The first preamble symbol is issued on the next sym_clk_ena edge.
- FSM state PREAMBLE:
  - On each sym_clk_ena: emit +3a when sym_count is even, -3a when odd. sym_bits = 10 / 00 respectively.
  - Increment sym_count.
  - After symbol PREAMBLE_LEN-1 is issued: sym_count <= 0, go to DATA.
- FSM state DATA:
  - On each sym_clk_ena: emit the LFSR-mapped symbol and increment sym_count.
  - On the edge issuing symbol FRAME_LEN-1: frame_done = 1 for exactly one clk, then go to IDLE with sym_count <= 0.
- busy: registered, high from the edge issuing preamble symbol 0 through the edge issuing the last data symbol.
  - busy falls on the next sym_clk_ena, together with the first IDLE zero symbol.
- Back-to-back frames: start asserted in the clk after frame_done yields a new PREAMBLE beginning one symbol (one zero symbol) later. There is no zero-gap guarantee beyond that one symbol.
- Enables low indefinitely: all state frozen, outputs held.
- sym_clk_ena without sam_clk_ena is illegal input and is treated as sym_clk_ena.
- reset mid-frame: returns to IDLE with all outputs 0 on the next edge, and clears start_pending.

Test Plan:
- Reset with enables running -> sam_out, sym_out, busy, frame_done all 0. sam_out stays 0 for 10 symbols with start low.
- Single-cycle start pulse -> 16 preamble symbols +98304, -98304, ... on sym_out. sam_out = +98304/-98304 for 4 clk after each sym_clk_ena and 0 in the other 12 clk of each symbol. busy rises at the first preamble symbol.
- Data phase with seed 0x0001 -> data symbols 0..6 = -98304 (bits 00), symbol 7 = +98304 (bits 10). sym_count runs 0..7.
- Frame end -> frame_done high exactly 1 clk, on the edge issuing data symbol 255. The next symbol is 0 and busy goes 0.
- start held high during DATA -> no restart and exactly 256 data symbols. start reasserted after frame_done -> one zero symbol, then a new preamble, then a data sequence identical to the first frame.
- reset asserted mid-DATA at symbol 100 -> all outputs 0 the next clk. A new start reproduces the sequence from data symbol 0.
